dmem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port: a multi-cycle load/store sequencer.
- Sits between the pipeline MEM stage and data_memory.
- Accepts one load or store per request handshake, supports byte, halfword and word sizes, and performs read-modify-write for sub-word stores.
- Drives MemAddr/MemRead/MemWrite/Write_Data and returns aligned, extended load data plus a pipeline stall.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_access_ctrl_lane.sv | 39 +++
 rtl/dmem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access controller: size codes, FSM states
// and the alignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP,
        ST_ERR
    } state_e;

    // A reserved size is never aligned, so it falls into the error path too.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side request/response handshake of the data-memory access controller.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/dmem_access_ctrl_lane.sv
// Little-endian lane logic: load extract with sign/zero extension, and the
// sub-word merge used by read-modify-write stores.
module mem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_data_o = '0;
        merged_o    = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i;
                else              merged_o[15:0]  = wdata_i;
            end
            SZ_WORD: load_data_o = rdata_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer between the MEM stage and data memory,
// with read-modify-write for byte and halfword stores.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              unsigned_q, unsigned_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              stall_q, stall_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              accept;

    mem_lane_unit u_lane (
        .rdata_i     (mem_rdata),
        .size_i      (size_q),
        .unsigned_i  (unsigned_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q[15:0]),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    assign accept = bus.req_valid && req_ready_q;

    // Outputs are decoded from the next state and registered, so each one is
    // a pure function of the state it is shown in.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        resp_rdata_d = '0;
        mem_wdata_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = bus.req_addr;
                    size_d     = bus.req_size;
                    write_d    = bus.req_write;
                    unsigned_d = bus.req_unsigned;
                    wdata_d    = bus.req_wdata;
                    if (!is_aligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else if (!bus.req_write) begin
                        state_d = ST_RD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_d     = ST_WR;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                resp_rdata_d = write_q ? '0 : load_data;
                state_d      = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_wdata_d = merged;
                state_d     = ST_RMW_WR;
            end
            ST_WR, ST_RMW_WR: state_d = ST_RESP;
            default:          state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        stall_d      = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_RESP) || (state_d == ST_ERR);
        resp_err_d   = (state_d == ST_ERR);
        mem_read_d   = (state_d == ST_RD) || (state_d == ST_RMW_RD);
        mem_write_d  = (state_d == ST_WR) || (state_d == ST_RMW_WR);
        mem_addr_d   = (mem_read_d || mem_write_d) ? addr_d : '0;
        if (state_d != ST_RESP) resp_rdata_d = '0;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            stall_q      <= stall_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.stall      = stall_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl against a small 8-word data memory model.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [8];

    int n_checks = 0;
    int n_pass   = 0;
    int both_hi  = 0;

    logic        saw_rd, saw_wr;
    logic [4:0]  addr_c1;
    logic        rd_c1;
    logic [31:0] wr_word;
    logic [31:0] rd;
    logic        err;
    int          lat;

    dmem_access_ctrl_if #(.ADDR_W(5)) bus ();

    dmem_access_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[4:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[4:2]] <= mem_wdata;
    always @(negedge clk) if (mem_read && mem_write) both_hi++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issues one request and follows it to its response, recording what the
    // memory port did on the way.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [4:0] addr, input logic [31:0] wd);
        logic got = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;  bus.req_write = wr;  bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clk);
        saw_rd = 1'b0; saw_wr = 1'b0; wr_word = '0; rd = '0; err = 1'b0; lat = 0;
        addr_c1 = '0; rd_c1 = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat = c;
            if (c == 1) begin addr_c1 = mem_addr; rd_c1 = mem_read; end
            if (mem_read) saw_rd = 1'b1;
            if (mem_write) begin saw_wr = 1'b1; wr_word = mem_wdata; end
            if (bus.resp_valid) begin got = 1'b1; rd = bus.resp_rdata; err = bus.resp_err; end
        end
        if (!got) check({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'(i * 10);
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ready", 32'(bus.req_ready), 32'd1);
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst mem rd/wr", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);

        do_req("lw12", 1'b0, SZ_WORD, 1'b0, 5'd12, '0);
        check("lw12 c1 mem_read", 32'(rd_c1), 32'd1);
        check("lw12 c1 mem_addr", 32'(addr_c1), 32'd12);
        check("lw12 lat", 32'(lat), 32'd2);
        check("lw12 data", rd, 32'd30);
        check("lw12 err", 32'(err), 32'd0);

        do_req("sb13", 1'b1, SZ_BYTE, 1'b0, 5'd13, 32'h000000AB);
        check("sb13 lat", 32'(lat), 32'd3);
        check("sb13 merged", wr_word, 32'h0000AB1E);
        check("sb13 rdata", rd, 32'd0);
        do_req("lw12b", 1'b0, SZ_WORD, 1'b0, 5'd12, '0);
        check("lw12b data", rd, 32'h0000AB1E);

        do_req("sw16", 1'b1, SZ_WORD, 1'b0, 5'd16, 32'h00000080);
        check("sw16 lat", 32'(lat), 32'd2);
        check("sw16 no read", 32'(saw_rd), 32'd0);
        do_req("lb16", 1'b0, SZ_BYTE, 1'b0, 5'd16, '0);
        check("lb16", rd, 32'hFFFFFF80);
        do_req("lbu16", 1'b0, SZ_BYTE, 1'b1, 5'd16, '0);
        check("lbu16", rd, 32'h00000080);
        do_req("lhu18", 1'b0, SZ_HALF, 1'b1, 5'd18, '0);
        check("lhu18", rd, 32'h00000000);
        do_req("sh18", 1'b1, SZ_HALF, 1'b0, 5'd18, 32'h1234BEEF);
        check("sh18 merged", wr_word, 32'hBEEF0080);
        do_req("lh18", 1'b0, SZ_HALF, 1'b0, 5'd18, '0);
        check("lh18", rd, 32'hFFFFBEEF);
        do_req("lb19", 1'b0, SZ_BYTE, 1'b1, 5'd19, '0);
        check("lbu19", rd, 32'h000000BE);

        do_req("lw14", 1'b0, SZ_WORD, 1'b0, 5'd14, '0);
        check("lw14 err", 32'(err), 32'd1);
        check("lw14 lat", 32'(lat), 32'd1);
        check("lw14 rdata", rd, 32'd0);
        check("lw14 no access", {30'd0, saw_rd, saw_wr}, 32'd0);
        do_req("sh5", 1'b1, SZ_HALF, 1'b0, 5'd5, 32'h0000FFFF);
        check("sh5 err", 32'(err), 32'd1);
        check("sh5 lat", 32'(lat), 32'd1);
        check("sh5 no access", {30'd0, saw_rd, saw_wr}, 32'd0);
        do_req("rsvd0", 1'b0, SZ_RSVD, 1'b0, 5'd0, '0);
        check("rsvd err", 32'(err), 32'd1);
        check("mem word1 intact", mem[1], 32'd10);
        check("mem word3 intact", mem[3], 32'h0000AB1E);

        // Back-to-back loads with req_valid held; fields change while busy.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = SZ_WORD;
        bus.req_unsigned = 1'b0; bus.req_addr = 5'd12;
        @(negedge clk);
        check("b2b rd ready", 32'(bus.req_ready), 32'd0);
        check("b2b rd stall", 32'(bus.stall), 32'd1);
        check("b2b rd addr", 32'(mem_addr), 32'd12);
        bus.req_addr = 5'd16;
        @(negedge clk);
        check("b2b resp1 valid", 32'(bus.resp_valid), 32'd1);
        check("b2b resp1 data", bus.resp_rdata, 32'h0000AB1E);
        check("b2b resp stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        check("b2b idle ready", 32'(bus.req_ready), 32'd1);
        check("b2b idle resp", {31'd0, bus.resp_valid}, 32'd0);
        check("b2b idle rdata", bus.resp_rdata, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b rd2 addr", 32'(mem_addr), 32'd16);
        check("b2b rd2 read", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("b2b resp2 valid", 32'(bus.resp_valid), 32'd1);
        check("b2b resp2 data", bus.resp_rdata, 32'hBEEF0080);

        // Reset asserted while the RMW write is on the bus.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_BYTE;
        bus.req_addr = 5'd0; bus.req_wdata = 32'h00000055;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmw rd phase", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("rmw wr phase", 32'(mem_write), 32'd1);
        check("rmw wr data", mem_wdata, 32'h00000055);
        #1 rst_n = 1'b0;
        #1;
        check("rst drop write", 32'(mem_write), 32'd0);
        check("rst drop read", 32'(mem_read), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst no commit", mem[0], 32'd0);
        rst_n = 1'b1;
        #1;
        check("post rst ready", 32'(bus.req_ready), 32'd1);
        check("post rst stall", 32'(bus.stall), 32'd0);
        check("post rst resp", 32'(bus.resp_valid), 32'd0);
        do_req("post rst lw16", 1'b0, SZ_WORD, 1'b0, 5'd16, '0);
        check("post rst lw16", rd, 32'hBEEF0080);

        check("never rd&wr", 32'(both_hi), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
